// File: rtl/video_timing_generator.sv
// video_timing_generator
//   Free-running raster timing generator: one pixel per clock. Walks an
//   (h,v) counter pair over the full raster (active + front porch + sync +
//   back porch in each direction) and registers the decoded timing signals.
//
//   Ports
//     clk          pixel clock, rising edge
//     rst          asynchronous active-high reset
//     x, y         pixel coordinate, forced to 0 outside the visible area
//     active       visible-area flag
//     hsync/vsync  sync outputs, pulse level set by HSYNC_ACTIVE/VSYNC_ACTIVE
//     line_start   one-cycle pulse on x=0 of each visible line
//     frame_start  one-cycle pulse on pixel (0,0) of each frame
//
//   The counters hold the pixel that the *next* edge will present, so every
//   output is a single register stage behind the counters and the first edge
//   after reset shows pixel (0,0).
module video_timing_generator #(
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int HOR_FRONT_PORCH   = 16,
  parameter int HOR_SYNC_PULSE    = 96,
  parameter int HOR_BACK_PORCH    = 48,
  parameter int VER_ACTIVE_PIXELS = 480,
  parameter int VER_FRONT_PORCH   = 10,
  parameter int VER_SYNC_PULSE    = 2,
  parameter int VER_BACK_PORCH    = 33,
  parameter bit HSYNC_ACTIVE      = 1'b0,
  parameter bit VSYNC_ACTIVE      = 1'b0,
  localparam int X_WIDTH = $clog2(HOR_ACTIVE_PIXELS),
  localparam int Y_WIDTH = $clog2(VER_ACTIVE_PIXELS)
) (
  input  logic               clk,
  input  logic               rst,
  output logic [X_WIDTH-1:0] x,
  output logic [Y_WIDTH-1:0] y,
  output logic               active,
  output logic               hsync,
  output logic               vsync,
  output logic               line_start,
  output logic               frame_start
);

  localparam int H_TOTAL = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC_PULSE + HOR_BACK_PORCH;
  localparam int V_TOTAL = VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC_PULSE + VER_BACK_PORCH;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  // Boundaries sized to the counters so comparisons stay width-matched.
  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END = HW'(HOR_ACTIVE_PIXELS);
  localparam logic [HW-1:0] H_SYN_BEG = HW'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH);
  localparam logic [HW-1:0] H_SYN_END = HW'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC_PULSE);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END = VW'(VER_ACTIVE_PIXELS);
  localparam logic [VW-1:0] V_SYN_BEG = VW'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH);
  localparam logic [VW-1:0] V_SYN_END = VW'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC_PULSE);

  logic [HW-1:0] h;
  logic [VW-1:0] v;

  // Raster position counters; v steps only on the h wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  // Decode of the pixel about to be presented.
  logic h_vis, v_vis, vis, h_in_sync, v_in_sync;

  always_comb begin
    h_vis     = (h < H_ACT_END);
    v_vis     = (v < V_ACT_END);
    vis       = h_vis && v_vis;
    h_in_sync = (h >= H_SYN_BEG) && (h < H_SYN_END);
    // v only moves on the h wrap, so vsync is naturally whole-line aligned.
    v_in_sync = (v >= V_SYN_BEG) && (v < V_SYN_END);
  end

  // Output register stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x           <= '0;
      y           <= '0;
      active      <= 1'b0;
      hsync       <= ~HSYNC_ACTIVE;
      vsync       <= ~VSYNC_ACTIVE;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // Blanking counts are never exposed on x/y, even truncated.
      x           <= vis ? h[X_WIDTH-1:0] : '0;
      y           <= vis ? v[Y_WIDTH-1:0] : '0;
      active      <= vis;
      hsync       <= h_in_sync ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
      vsync       <= v_in_sync ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
      line_start  <= vis && (h == '0);
      frame_start <= (h == '0) && (v == '0);
    end
  end

endmodule
